dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter DWELL_W, default 24: width of the per-point dwell counter.
REQ-002 Port clk, input, 1: single system clock (DAC clock domain).
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port cfg_valid, input, 1: configuration write request.
REQ-005 Port cfg_ready, output, 1: configuration accepted this cycle when high together with cfg_valid.
REQ-006 Ports cfg_f_start, cfg_f_stop and cfg_f_step, input, 32 each: sweep start, stop and step frequency words.
REQ-007 Port cfg_pha, input, 32: phase word.
REQ-008 Port cfg_wave, input, 2: 0=sine, 1=triangle, 2=sawtooth, 3=square.
REQ-009 Port cfg_dwell, input, DWELL_W: number of cycles per point minus one.
REQ-010 Port cfg_cont, input, 1: 1 = continuous (wrap) sweep, 0 = single sweep.
REQ-011 Port start, input, 1: start request.
REQ-012 Port abort, input, 1: stop request.
REQ-013 Ports fre_word and pha_word, output, 32 each: registered words driven to the DDS.
REQ-014 Port wave_type, output, 2: registered waveform select.
REQ-015 Port busy, output, 1: high when state is not IDLE.
REQ-016 Port done, output, 1: one-cycle pulse at the end of a single sweep.
REQ-017 Port wrap, output, 1: one-cycle pulse on each continuous-sweep wrap.

Function
REQ-018 States: IDLE, LOAD, DWELL, DONE.
REQ-019 cfg_ready SHALL be high only in IDLE; on cfg_valid&&cfg_ready, all cfg_* values are latched into shadow registers.
REQ-020 In IDLE, a start pulse moves the FSM to LOAD; cfg handshake and start in the same cycle SHALL use the newly latched config.
REQ-021 In LOAD (1 cycle):
- fre_word<=f_start, pha_word<=pha, wave_type<=wave.
- Dwell counter<=dwell.
- Next state DWELL.
- Result: start seen in cycle N gives new outputs visible in cycle N+2.
REQ-022 DWELL: the counter decrements each cycle; at counter==0 the next point is computed and the counter is reloaded, so each point is held exactly dwell+1 cycles.
REQ-023 Next point: nxt = fre_word + f_step, computed 33 bits wide; nxt>f_stop or carry set constitutes the end of sweep.
REQ-024 At end of sweep with cont=1: fre_word<=f_start, wrap pulses, stay in DWELL.
REQ-025 At end of sweep with cont=0: fre_word held, next state DONE.
REQ-026 f_step==0: the tone SHALL hold at f_start indefinitely; no done and no wrap are produced.
REQ-027 f_start>f_stop: single point; after one dwell, DONE (cont=0) or reload f_start with a wrap pulse (cont=1).
REQ-028 DONE (1 cycle): done=1, next state IDLE; fre_word, pha_word and wave_type retain their values.
REQ-029 abort in any non-IDLE state SHALL go to IDLE next cycle:
- Outputs hold.
- No done pulse.
- abort beats start in the same cycle.
REQ-030 start while busy SHALL be ignored; cfg_valid while busy is not accepted.

Reset
REQ-031 rst_n low SHALL asynchronously force:
- State IDLE.
- fre_word, pha_word, wave_type, busy, done, wrap and all shadow registers to 0.
- Dwell counter to 0.
REQ-032 Reset mid-sweep SHALL behave identically to REQ-031; the first start after reset requires a fresh config or runs with all-zero config.

Structure
REQ-033 Package dds_ctrl_pkg SHALL hold the FSM state enum and wave-type constants (SIN, TRI, SAW, SQR).
REQ-034 The dwell down-counter with load/zero flag SHALL be sub-module dds_dwell_timer.

Verification
REQ-035 Single sweep: cfg f_start=100, f_stop=400, f_step=100, dwell=2, cont=0, start -> fre_word 100, 200, 300, 400, each held 3 cycles; done pulses once; busy drops after.
REQ-036 Continuous sweep: same config with cont=1 -> after 400, fre_word=100 and wrap=1 for one cycle; repeats for 3 periods.
REQ-037 Overflow: f_start=0xFFFF_FF00, f_stop=0xFFFF_FFFF, f_step=0x80, dwell=0 -> fre_word FF00, FF80, then done (carry end); no wrap to a small value.
REQ-038 Abort: abort in the 2nd point of REQ-035 -> IDLE next cycle, fre_word=200 held, done=0; simultaneous start+abort in IDLE -> stays IDLE.
REQ-039 Handshake: cfg_valid during busy -> cfg_ready=0 and shadow unchanged; cfg_valid+start same IDLE cycle -> new f_start on fre_word at N+2.
REQ-040 Async reset asserted mid-DWELL between clock edges -> all outputs 0 immediately; cfg_ready=1 after release.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// rtl/dds_ctrl_pkg.sv - shared types and constants for the DDS sweep controller
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SIN = 2'd0;
  localparam logic [1:0] TRI = 2'd1;
  localparam logic [1:0] SAW = 2'd2;
  localparam logic [1:0] SQR = 2'd3;

  // Carry bit kept so an overflowing step ends the sweep instead of wrapping low.
  function automatic logic [32:0] next_point(input logic [31:0] fre, input logic [31:0] step);
    return {1'b0, fre} + {1'b0, step};
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// rtl/dds_dwell_timer.sv - per-point dwell down-counter with load and zero flag
module dds_dwell_timer #(
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency sweep sequencer driving DDS frequency/phase/wave words
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_f_start,
  input  logic [31:0]        cfg_f_stop,
  input  logic [31:0]        cfg_f_step,
  input  logic [31:0]        cfg_pha,
  input  logic [1:0]         cfg_wave,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_cont,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        fre_word,
  output logic [31:0]        pha_word,
  output logic [1:0]         wave_type,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_e state_q, state_d;

  logic [31:0]        f_start_q, f_stop_q, f_step_q, pha_q;
  logic [1:0]         wave_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;

  logic [31:0] fre_q, fre_d;
  logic [31:0] pha_out_q, pha_out_d;
  logic [1:0]  wave_out_q, wave_out_d;
  logic        wrap_q, wrap_d;

  logic        tmr_load, tmr_dec, tmr_zero;
  logic [32:0] nxt;
  logic        sweep_end;
  logic        cfg_fire;

  assign cfg_ready = (state_q == S_IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      pha_q     <= '0;
      wave_q    <= '0;
      dwell_q   <= '0;
      cont_q    <= 1'b0;
    end else if (cfg_fire) begin
      f_start_q <= cfg_f_start;
      f_stop_q  <= cfg_f_stop;
      f_step_q  <= cfg_f_step;
      pha_q     <= cfg_pha;
      wave_q    <= cfg_wave;
      dwell_q   <= cfg_dwell;
      cont_q    <= cfg_cont;
    end
  end

  dds_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (dwell_q),
    .zero_o     (tmr_zero)
  );

  // A zero step never terminates: the tone parks on f_start until aborted.
  assign nxt       = next_point(fre_q, f_step_q);
  assign sweep_end = (f_step_q != '0) && (nxt[32] || (nxt[31:0] > f_stop_q));

  always_comb begin
    state_d    = state_q;
    fre_d      = fre_q;
    pha_out_d  = pha_out_q;
    wave_out_d = wave_out_q;
    wrap_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          fre_d      = f_start_q;
          pha_out_d  = pha_q;
          wave_out_d = wave_q;
          tmr_load   = 1'b1;
          state_d    = S_DWELL;
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          if (!sweep_end) begin
            fre_d = nxt[31:0];
          end else if (cont_q) begin
            fre_d  = f_start_q;
            wrap_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fre_q      <= '0;
      pha_out_q  <= '0;
      wave_out_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fre_q      <= fre_d;
      pha_out_q  <= pha_out_d;
      wave_out_q <= wave_out_d;
      wrap_q     <= wrap_d;
    end
  end

  assign fre_word  = fre_q;
  assign pha_word  = pha_out_q;
  assign wave_type = wave_out_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - self-checking bench for dds_sweep_ctrl against a point-list model
module tb_dds_sweep_ctrl;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [31:0]   cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0, cfg_pha = '0;
  logic [1:0]    cfg_wave = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          cfg_cont = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [31:0]   fre_word, pha_word;
  logic [1:0]    wave_type;
  logic          busy, done, wrap;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_pha(cfg_pha), .cfg_wave(cfg_wave), .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont),
    .start(start), .abort(abort),
    .fre_word(fre_word), .pha_word(pha_word), .wave_type(wave_type),
    .busy(busy), .done(done), .wrap(wrap)
  );

  typedef struct {
    logic [31:0]   f_start, f_stop, f_step, pha;
    logic [1:0]    wave;
    logic [DW-1:0] dwell;
    bit            cont;
  } cfg_t;

  typedef struct {
    logic [31:0] fre;
    bit          done;
    bit          wrap;
  } exp_t;

  int checks = 0;
  int errors = 0;

  cfg_t        sh;
  logic [31:0] m_fre = '0, m_pha = '0;
  logic [1:0]  m_wave = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_cfg(input cfg_t c, input bit v);
    cfg_valid   = v;
    cfg_f_start = c.f_start;
    cfg_f_stop  = c.f_stop;
    cfg_f_step  = c.f_step;
    cfg_pha     = c.pha;
    cfg_wave    = c.wave;
    cfg_dwell   = c.dwell;
    cfg_cont    = c.cont;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".wrap"}, wrap, 0);
    chk({tag, ".cfg_ready"}, cfg_ready, 1);
    chk({tag, ".fre"}, fre_word, m_fre);
    chk({tag, ".pha"}, pha_word, m_pha);
    chk({tag, ".wave"}, wave_type, m_wave);
  endtask

  task automatic chk_run(input string tag, input exp_t e);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".done"}, done, e.done);
    chk({tag, ".wrap"}, wrap, e.wrap);
    chk({tag, ".cfg_ready"}, cfg_ready, 0);
    chk({tag, ".fre"}, fre_word, e.fre);
    chk({tag, ".pha"}, pha_word, m_pha);
    chk({tag, ".wave"}, wave_type, m_wave);
  endtask

  // Launches a sweep; abort_at/rst_at index the expected per-cycle trace (-1 = none).
  task automatic sweep(input string tag, input cfg_t c, input bit send, input int periods,
                       input int abort_at, input bit abort_load, input int rst_at);
    exp_t            tr[$];
    exp_t            e;
    longint unsigned pts[$];
    longint unsigned p, n;
    cfg_t            junk;
    int              ab, sz;

    if (send) sh = c;
    drive_cfg(c, send);
    start = 1'b1;
    chk({tag, ".ready_at_start"}, cfg_ready, 1);
    tick();
    start = 1'b0;
    cfg_valid = 1'b0;
    chk({tag, ".load.busy"}, busy, 1);
    chk({tag, ".load.fre_old"}, fre_word, m_fre);
    chk({tag, ".load.ready"}, cfg_ready, 0);
    if (abort_load) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle({tag, ".abort_load"});
      return;
    end
    tick();
    m_pha  = sh.pha;
    m_wave = sh.wave;

    if (sh.f_step == 0) begin
      for (int i = 0; i < 3 * (int'(sh.dwell) + 1) + 4; i++) begin
        e.fre = sh.f_start; e.done = 0; e.wrap = 0;
        tr.push_back(e);
      end
    end else begin
      p = longint'(sh.f_start);
      forever begin
        pts.push_back(p);
        n = p + longint'(sh.f_step);
        if (n > longint'(sh.f_stop) || n > 64'h0000_0000_FFFF_FFFF || pts.size() >= 64) break;
        p = n;
      end
      for (int per = 0; per < (sh.cont ? periods : 1); per++) begin
        for (int k = 0; k < pts.size(); k++) begin
          for (int d = 0; d <= int'(sh.dwell); d++) begin
            e.fre  = 32'(pts[k]);
            e.done = 0;
            e.wrap = (per > 0) && (k == 0) && (d == 0);
            tr.push_back(e);
          end
        end
      end
      if (!sh.cont) begin
        e.fre = 32'(pts[pts.size() - 1]); e.done = 1; e.wrap = 0;
        tr.push_back(e);
      end
    end

    sz = tr.size();
    ab = abort_at;
    if (sh.cont || sh.f_step == 0) begin
      if (ab < 0 || ab > sz - 1) ab = sz - 1;
    end else if (ab > sz - 2) begin
      ab = sz - 2;
    end

    for (int i = 0; i < sz; i++) begin
      chk_run($sformatf("%s[%0d]", tag, i), tr[i]);
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".rst.fre"}, fre_word, 0);
        chk({tag, ".rst.pha"}, pha_word, 0);
        chk({tag, ".rst.wave"}, wave_type, 0);
        chk({tag, ".rst.busy"}, busy, 0);
        chk({tag, ".rst.done"}, done, 0);
        chk({tag, ".rst.wrap"}, wrap, 0);
        cfg_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sh = '{default: 0};
        m_fre = '0; m_pha = '0; m_wave = '0;
        chk_idle({tag, ".after_rst"});
        return;
      end
      junk.f_start = $urandom; junk.f_stop = $urandom; junk.f_step = $urandom;
      junk.pha = $urandom; junk.wave = 2'($urandom); junk.dwell = DW'($urandom);
      junk.cont = 1'($urandom);
      drive_cfg(junk, 1'($urandom_range(0, 1)));
      start = 1'($urandom_range(0, 1));
      if (i == ab) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cfg_valid = 1'b0;
        start = 1'b0;
        m_fre = tr[i].fre;
        chk_idle({tag, ".aborted"});
        return;
      end
      tick();
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    m_fre = tr[sz - 1].fre;
    chk_idle({tag, ".end"});
  endtask

  cfg_t c035, c037, cfg_x;

  initial begin
    sh = '{default: 0};
    c035 = '{f_start: 32'd100, f_stop: 32'd400, f_step: 32'd100, pha: 32'h1234_5678,
             wave: 2'd1, dwell: DW'(2), cont: 0};
    c037 = '{f_start: 32'hFFFF_FF00, f_stop: 32'hFFFF_FFFF, f_step: 32'h80, pha: 32'hA5A5_0001,
             wave: 2'd3, dwell: DW'(0), cont: 0};

    #2;
    chk("reset.fre", fre_word, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.wrap", wrap, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("reset_release");

    sweep("single", c035, 1, 1, -1, 0, -1);
    cfg_x = c035; cfg_x.cont = 1;
    sweep("cont", cfg_x, 1, 3, -1, 0, -1);
    sweep("overflow", c037, 1, 1, -1, 0, -1);
    sweep("abort_p2", c035, 1, 1, 4, 0, -1);
    chk("abort_p2.held200", m_fre, 200);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort_idle");
    tick();
    chk_idle("start_abort_idle2");

    sweep("reuse_shadow", cfg_x, 0, 1, -1, 0, -1);
    cfg_x = '{f_start: 32'd7, f_stop: 32'd9, f_step: 32'd1, pha: 32'd55, wave: 2'd2,
              dwell: DW'(1), cont: 0};
    sweep("abort_load", cfg_x, 1, 1, -1, 1, -1);
    cfg_x = '{f_start: 32'd500, f_stop: 32'd100, f_step: 32'd10, pha: 32'd3, wave: 2'd0,
              dwell: DW'(3), cont: 0};
    sweep("single_point", cfg_x, 1, 1, -1, 0, -1);
    cfg_x.cont = 1;
    sweep("single_point_cont", cfg_x, 1, 3, -1, 0, -1);
    cfg_x = '{f_start: 32'd50, f_stop: 32'd1000, f_step: 32'd0, pha: 32'd9, wave: 2'd1,
              dwell: DW'(1), cont: 1};
    sweep("step_zero", cfg_x, 1, 1, -1, 0, -1);
    sweep("reset_mid", c035, 1, 1, -1, 0, 4);
    sweep("zero_cfg", c035, 0, 1, -1, 0, -1);

    for (int it = 0; it < 14; it++) begin
      longint unsigned stopl;
      int k;
      cfg_x.f_start = $urandom;
      cfg_x.f_step  = $urandom_range(1, 1 << 24);
      k = $urandom_range(0, 4);
      stopl = longint'(cfg_x.f_start) + longint'(k) * longint'(cfg_x.f_step)
              + longint'($urandom_range(0, cfg_x.f_step - 1));
      if (stopl > 64'h0000_0000_FFFF_FFFF) stopl = 64'h0000_0000_FFFF_FFFF;
      cfg_x.f_stop = 32'(stopl);
      if ($urandom_range(0, 5) == 0 && cfg_x.f_start != 0) cfg_x.f_stop = cfg_x.f_start - 1;
      cfg_x.pha   = $urandom;
      cfg_x.wave  = 2'($urandom_range(0, 3));
      cfg_x.dwell = DW'($urandom_range(0, 3));
      cfg_x.cont  = 1'($urandom_range(0, 1));
      sweep($sformatf("rnd%0d", it), cfg_x, 1, $urandom_range(2, 3),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
